// File: rtl/alu_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_ex_stage                                                 |
// | Description : Execute-stage ALU plus EX/MEM output register with a         |
// |               valid/ready handshake, flush and back-pressure support.      |
// |               Optional macro ALU_OVF_TRAP_EN adds the ovf output and       |
// |               suppresses writeback on signed add/sub overflow.             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module alu_ex_stage #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            aluctrl,
  input  logic [WIDTH-1:0]      src_a,
  input  logic [WIDTH-1:0]      src_b,
  input  logic [WIDTH-1:0]      store_data_in,
  input  logic [REG_ADDR_W-1:0] wreg_in,
  input  logic                  regwrite_in,
  input  logic                  memread_in,
  input  logic                  memwrite_in,
  input  logic                  flush,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      result,
  output logic                  zero,
  output logic [WIDTH-1:0]      store_data_out,
  output logic [REG_ADDR_W-1:0] wreg_out,
  output logic                  regwrite_out,
  output logic                  memread_out,
`ifdef ALU_OVF_TRAP_EN
  output logic                  ovf,
`endif
  output logic                  memwrite_out
);

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_OR  = 3'b011;
  localparam logic [2:0] c_OP_XOR = 3'b100;
  localparam logic [2:0] c_OP_NOR = 3'b101;
  localparam logic [2:0] c_OP_SLT = 3'b110;

  logic                  w_accept;
  logic [WIDTH-1:0]      w_sum;
  logic [WIDTH-1:0]      w_diff;
  logic                  w_slt;
  logic [WIDTH-1:0]      w_result;
  logic                  w_ovf;
  logic                  w_regwrite_nxt;

  logic                  r_out_valid;
  logic [WIDTH-1:0]      r_result;
  logic                  r_zero;
  logic [WIDTH-1:0]      r_store_data;
  logic [REG_ADDR_W-1:0] r_wreg;
  logic                  r_regwrite;
  logic                  r_memread;
  logic                  r_memwrite;
  logic                  r_ovf;

  // Ready whenever the output register is empty or being drained this cycle.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready && !flush;

  assign w_sum  = src_a + src_b;
  assign w_diff = src_a - src_b;
  assign w_slt  = $signed(src_a) < $signed(src_b);

  // ALU operation select; the reserved code yields zero.
  always_comb begin
    w_result = '0;
    case (aluctrl)
      c_OP_ADD: w_result = w_sum;
      c_OP_SUB: w_result = w_diff;
      c_OP_AND: w_result = src_a & src_b;
      c_OP_OR:  w_result = src_a | src_b;
      c_OP_XOR: w_result = src_a ^ src_b;
      c_OP_NOR: w_result = ~(src_a | src_b);
      c_OP_SLT: w_result = {{(WIDTH-1){1'b0}}, w_slt};
      default:  w_result = '0;
    endcase
  end

`ifdef ALU_OVF_TRAP_EN
  // Signed overflow: operands agree in sign (add) or differ (sub) and the
  // wrapped result's sign disagrees with operand A.
  always_comb begin
    w_ovf = 1'b0;
    if (aluctrl == c_OP_ADD)
      w_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (w_sum[WIDTH-1] != src_a[WIDTH-1]);
    else if (aluctrl == c_OP_SUB)
      w_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (w_diff[WIDTH-1] != src_a[WIDTH-1]);
  end
  assign w_regwrite_nxt = regwrite_in && !w_ovf;
  assign ovf            = r_ovf;
`else
  assign w_ovf          = 1'b0;
  assign w_regwrite_nxt = regwrite_in;
`endif

  // EX/MEM register: reset, then flush, then accept, then drain, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_result     <= '0;
      r_zero       <= 1'b0;
      r_store_data <= '0;
      r_wreg       <= '0;
      r_regwrite   <= 1'b0;
      r_memread    <= 1'b0;
      r_memwrite   <= 1'b0;
      r_ovf        <= 1'b0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_regwrite   <= 1'b0;
      r_memread    <= 1'b0;
      r_memwrite   <= 1'b0;
      r_ovf        <= 1'b0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_result     <= w_result;
      r_zero       <= (w_result == '0);
      r_store_data <= store_data_in;
      r_wreg       <= wreg_in;
      r_regwrite   <= w_regwrite_nxt;
      r_memread    <= memread_in;
      r_memwrite   <= memwrite_in;
      r_ovf        <= w_ovf;
    end else if (r_out_valid && out_ready) begin
      r_out_valid  <= 1'b0;
      r_regwrite   <= 1'b0;
      r_memread    <= 1'b0;
      r_memwrite   <= 1'b0;
      r_ovf        <= 1'b0;
    end
  end

  assign out_valid      = r_out_valid;
  assign result         = r_result;
  assign zero           = r_zero;
  assign store_data_out = r_store_data;
  assign wreg_out       = r_wreg;
  assign regwrite_out   = r_regwrite;
  assign memread_out    = r_memread;
  assign memwrite_out   = r_memwrite;

`ifndef ALU_OVF_TRAP_EN
  // Overflow flag register is unused when the trap is not built in.
  logic w_unused_ovf;
  assign w_unused_ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_ex_stage                                              |
// | Description : Self-checking bench for alu_ex_stage: vector table, hand     |
// |               sequences for stall/flush/reset, and random traffic against  |
// |               a transaction-level reference model.                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_alu_ex_stage;
  localparam int W  = 32;
  localparam int RW = 5;
`ifdef ALU_OVF_TRAP_EN
  localparam bit c_OVF_EN = 1'b1;
`else
  localparam bit c_OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, flush, out_ready;
  logic [2:0]    aluctrl;
  logic [W-1:0]  src_a, src_b, store_data_in;
  logic [RW-1:0] wreg_in;
  logic          regwrite_in, memread_in, memwrite_in;
  logic          out_valid, zero, regwrite_out, memread_out, memwrite_out;
  logic [W-1:0]  result, store_data_out;
  logic [RW-1:0] wreg_out;
  logic          ovf;
`ifndef ALU_OVF_TRAP_EN
  assign ovf = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state: the instruction the EX/MEM register should hold.
  logic          m_valid, m_zero, m_rw, m_mr, m_mw, m_ovf;
  logic [W-1:0]  m_res, m_sd;
  logic [RW-1:0] m_wreg;

  always #5 clk = ~clk;

  alu_ex_stage #(.WIDTH(W), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .aluctrl(aluctrl), .src_a(src_a), .src_b(src_b),
    .store_data_in(store_data_in), .wreg_in(wreg_in),
    .regwrite_in(regwrite_in), .memread_in(memread_in), .memwrite_in(memwrite_in),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .result(result), .zero(zero), .store_data_out(store_data_out),
    .wreg_out(wreg_out), .regwrite_out(regwrite_out), .memread_out(memread_out),
`ifdef ALU_OVF_TRAP_EN
    .ovf(ovf),
`endif
    .memwrite_out(memwrite_out)
  );

  // Reference ALU from the operation definitions.
  function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~(a | b);
      3'd6: return ($signed(a) < $signed(b)) ? 1 : 0;
      default: return '0;
    endcase
  endfunction

  // Overflow judged by exact 64-bit signed arithmetic against the 32-bit range.
  function automatic logic ref_ovf(input logic [2:0] op, input logic [W-1:0] a, b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 3'd0)      r = sa + sb;
    else if (op == 3'd1) r = sa - sb;
    else                 return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic model_edge();
    logic ov;
    if (rst) begin
      {m_valid, m_res, m_zero, m_sd, m_wreg, m_rw, m_mr, m_mw, m_ovf} = '0;
    end else if (flush) begin
      {m_valid, m_rw, m_mr, m_mw, m_ovf} = '0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      ov      = c_OVF_EN && ref_ovf(aluctrl, src_a, src_b);
      m_valid = 1'b1;
      m_res   = ref_alu(aluctrl, src_a, src_b);
      m_zero  = (m_res == 0);
      m_sd    = store_data_in;
      m_wreg  = wreg_in;
      m_rw    = regwrite_in && !ov;
      m_mr    = memread_in;
      m_mw    = memwrite_in;
      m_ovf   = ov;
    end else if (m_valid && out_ready) begin
      {m_valid, m_rw, m_mr, m_mw, m_ovf} = '0;
    end
  endtask

  function automatic logic [74:0] dut_pack();
    return {out_valid, result, zero, store_data_out, wreg_out,
            regwrite_out, memread_out, memwrite_out, ovf};
  endfunction

  function automatic logic [74:0] model_pack();
    return {m_valid, m_res, m_zero, m_sd, m_wreg, m_rw, m_mr, m_mw, m_ovf};
  endfunction

  task automatic chk(input string name, input logic [74:0] got, input logic [74:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: check in_ready before the edge, advance model, check outputs after.
  task automatic tick(input string name);
    #3;
    chk({name, ":in_ready"}, 75'(in_ready), 75'(!m_valid || out_ready));
    @(posedge clk);
    model_edge();
    #1;
    chk({name, ":regs"}, dut_pack(), model_pack());
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] a, b,
                       input logic rwi, input logic [RW-1:0] wr);
    in_valid = v; aluctrl = op; src_a = a; src_b = b;
    regwrite_in = rwi; wreg_in = wr;
    store_data_in = a ^ 32'h5A5A_0000; memread_in = 1'b0; memwrite_in = 1'b0;
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    logic         exp_zero;
    logic         exp_rw;
    logic         exp_ovf;
  } vec_t;

  vec_t vt[12];
  logic [74:0] snap;

  initial begin
    vt[0]  = '{3'b000, 32'd5,          32'd7,          32'd12,         1'b0, 1'b1, 1'b0};
    vt[1]  = '{3'b001, 32'h1234,       32'h1234,       32'd0,          1'b1, 1'b1, 1'b0};
    vt[2]  = '{3'b110, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b1, 1'b0};
    vt[3]  = '{3'b110, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1, 1'b1, 1'b0};
    vt[4]  = '{3'b010, 32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  1'b0, 1'b1, 1'b0};
    vt[5]  = '{3'b011, 32'hF000_0001,  32'h000F_0002,  32'hF00F_0003,  1'b0, 1'b1, 1'b0};
    vt[6]  = '{3'b100, 32'hAAAA_5555,  32'hFFFF_0000,  32'h5555_5555,  1'b0, 1'b1, 1'b0};
    vt[7]  = '{3'b101, 32'hF0F0_0000,  32'h0F0F_0000,  32'h0000_FFFF,  1'b0, 1'b1, 1'b0};
    vt[8]  = '{3'b111, 32'hDEAD_BEEF,  32'h1,          32'd0,          1'b1, 1'b1, 1'b0};
    vt[9]  = '{3'b000, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, !c_OVF_EN, c_OVF_EN};
    vt[10] = '{3'b001, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, !c_OVF_EN, c_OVF_EN};
    vt[11] = '{3'b000, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b1, 1'b0};

    // Reset state.
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 3'b000, '0, '0, 1'b0, '0);
    {m_valid, m_res, m_zero, m_sd, m_wreg, m_rw, m_mr, m_mw, m_ovf} = '1;
    tick("reset0");
    tick("reset1");
    chk("reset_all_zero", dut_pack(), '0);
    rst = 1'b0;

    // Vector table, full throughput.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vt[i].op, vt[i].a, vt[i].b, 1'b1, 5'd3);
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_result", i), 75'(result), 75'(vt[i].exp_res));
      chk($sformatf("vec%0d_flags", i),
          75'({out_valid, zero, regwrite_out, wreg_out, ovf}),
          75'({1'b1, vt[i].exp_zero, vt[i].exp_rw, 5'd3, vt[i].exp_ovf}));
    end

    // Back-pressure: hold for three cycles, then drain and accept with no bubble.
    drive(1'b1, 3'b000, 32'd10, 32'd20, 1'b1, 5'd7);
    tick("stall_load");
    snap = dut_pack();
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'd100, 32'd1, 1'b1, 5'd9);
    for (int i = 0; i < 3; i++) begin
      tick("stall_hold");
      chk("stall_stable", dut_pack(), snap);
      chk("stall_in_ready", 75'(in_ready), 75'(0));
    end
    out_ready = 1'b1;
    tick("stall_release");
    chk("no_bubble", 75'({out_valid, result, wreg_out}), 75'({1'b1, 32'd101, 5'd9}));

    // Flush while holding a valid instruction and offering a new one.
    drive(1'b1, 3'b000, 32'd1, 32'd1, 1'b1, 5'd4);
    memread_in = 1'b1; memwrite_in = 1'b1; flush = 1'b1;
    tick("flush");
    chk("flush_ctrl", 75'({out_valid, regwrite_out, memread_out, memwrite_out, ovf}), 75'(0));
    flush = 1'b0;

    // Reset in the middle of a stall.
    drive(1'b1, 3'b001, 32'd50, 32'd8, 1'b1, 5'd12);
    memread_in = 1'b1;
    tick("rst_load");
    out_ready = 1'b0;
    tick("rst_stall");
    rst = 1'b1;
    tick("rst_mid");
    chk("rst_mid_zero", dut_pack(), '0);
    rst = 1'b0; out_ready = 1'b1;
    drive(1'b1, 3'b000, 32'd2, 32'd3, 1'b1, 5'd1);
    tick("post_rst");
    chk("post_rst_acc", 75'({out_valid, result, regwrite_out}), 75'({1'b1, 32'd5, 1'b1}));

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      in_valid      = ($urandom_range(0, 3) != 0);
      out_ready     = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 15) == 0);
      rst           = ($urandom_range(0, 63) == 0);
      aluctrl       = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: begin src_a = 32'($urandom_range(0, 3)); src_b = 32'($urandom_range(0, 3)); end
        1: begin src_a = 32'h7FFF_FFFF - 32'($urandom_range(0, 2));
                 src_b = 32'h8000_0000 + 32'($urandom_range(0, 2)); end
        default: begin src_a = $urandom(); src_b = $urandom(); end
      endcase
      store_data_in = $urandom();
      wreg_in       = 5'($urandom());
      regwrite_in   = 1'($urandom());
      memread_in    = 1'($urandom());
      memwrite_in   = 1'($urandom());
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
Execute-stage ALU with its EX/MEM output register for the pipelined MIPS core. It sits directly downstream of the ALU-control decoder and consumes its 3-bit aluctrl code plus the ID/EX operands. It computes the result and zero flag, then registers them with the MEM-stage control bits behind a valid/ready handshake. The handshake supports load-use stalls and branch flushes.

Parameters:
WIDTH, 32, datapath width of operands and result
REG_ADDR_W, 5, width of destination register index

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  ID/EX presents a valid instruction
in_ready  output  1  stage can accept this cycle
aluctrl  input  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor, 110 slt, 111 reserved
src_a  input  WIDTH  operand A (rs, post-forwarding)
src_b  input  WIDTH  operand B (rt or sign-extended immediate)
store_data_in  input  WIDTH  rt value for sw
wreg_in  input  REG_ADDR_W  destination register
regwrite_in  input  1  writeback enable
memread_in  input  1  lw
memwrite_in  input  1  sw
flush  input  1  kill the instruction being accepted and the one held in the output register
out_ready  input  1  MEM stage accepts
out_valid  output  1  EX/MEM register holds a valid instruction
result  output  WIDTH  registered ALU result / memory address
zero  output  1  registered (result == 0), used by bne
store_data_out  output  WIDTH  registered store data
wreg_out  output  REG_ADDR_W  registered destination
regwrite_out  output  1  registered writeback enable
memread_out  output  1  registered lw
memwrite_out  output  1  registered sw

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset drives out_valid, result, zero, store_data_out, wreg_out, regwrite_out, memread_out and memwrite_out to 0.
- Latency is 1 cycle: the operation is accepted at edge N and appears on the outputs after edge N.
- in_ready = !out_valid || out_ready. It is combinational and does not depend on in_valid.
- accept = in_valid && in_ready && !flush.
- Arithmetic:
  - add/sub are modulo 2^WIDTH.
  - and, or, xor and nor are bitwise.
  - slt is a signed compare; result = {WIDTH-1 zeros, (signed a < signed b)}.
  - Reserved code 111 gives result 0.
- zero is computed from the registered result value, so zero=1 for code 111.
- Register update priority at each edge:
  1. rst: all outputs cleared.
  2. flush: out_valid <= 0 and regwrite/memread/memwrite_out <= 0. Data fields may hold their values.
  3. accept: every output loads and out_valid <= 1.
  4. out_valid && out_ready, no accept: out_valid <= 0, control bits <= 0.
  5. Otherwise all outputs hold.
- Back-pressure: while out_valid=1 and out_ready=0, every output stays bit-stable and in_ready=0.
- Simultaneous drain and accept (out_valid=1, out_ready=1, in_valid=1) gives full throughput with no bubble.
- Control bits are 0 whenever out_valid=0.
- Reset in mid-stall discards the held instruction. The first accept after reset behaves like a normal accept.

Optional Feature:
ALU_OVF_TRAP_EN
- Defined:
  - Adds output port ovf (1 bit, reset 0) to the EX/MEM register.
  - ovf is set when signed overflow occurs on code 000 or 001; it is 0 for all other codes.
  - On overflow the registered regwrite_out is forced to 0 to suppress writeback; result is still the wrapped sum.
  - ovf follows the same priority rules as the control bits.
- Undefined: the ovf port is absent. add/sub wrap silently and regwrite_out passes through unchanged.

Test Plan:
- Reset, then in_valid=1, aluctrl=000, a=5, b=7, regwrite=1, wreg=3, out_ready=1 -> next cycle out_valid=1, result=12, zero=0, wreg_out=3, regwrite_out=1.
- aluctrl=001, a=b=0x1234 -> result=0, zero=1.
- aluctrl=110, a=0xFFFFFFFF, b=1 -> result=1; swap operands -> result=0.
- Load, then hold out_ready=0 for 3 cycles while in_valid=1 with new data -> outputs unchanged and in_ready=0. Raise out_ready -> new instruction appears the next cycle with no bubble.
- flush=1 together with in_valid=1 while out_valid=1 -> next cycle out_valid=0 and regwrite/memread/memwrite_out=0.
- aluctrl=000, a=0x7FFFFFFF, b=1, regwrite=1:
  - With ALU_OVF_TRAP_EN -> result=0x80000000, ovf=1, regwrite_out=0.
  - Without -> result=0x80000000, regwrite_out=1.
- Assert rst while stalled with out_valid=1 -> next cycle all outputs 0.
